// File: rtl/i2c_rtc_pkg.sv
// Shared types and constants for the I2C RTC target: FSM states, RTC register
// indices and bus acknowledge levels.
package i2c_rtc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_MACK,
    IGNORE
  } i2c_state_e;

  localparam logic [2:0] REG_SEC  = 3'd0;
  localparam logic [2:0] REG_MIN  = 3'd1;
  localparam logic [2:0] REG_HOUR = 3'd2;
  localparam logic [2:0] REG_DAY  = 3'd3;
  localparam logic [2:0] REG_DATE = 3'd4;
  localparam logic [2:0] REG_MON  = 3'd5;
  localparam logic [2:0] REG_YEAR = 3'd6;
  localparam logic [2:0] REG_CTRL = 3'd7;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_rtc_target_if.sv
// Board-side bundle of the RTC target: raw I2C line levels, open-drain SDA
// enable, status, write-notify strobe and the local register read port.
interface i2c_rtc_target_if #(parameter int NUM_REGS = 8);

  localparam int IW = $clog2(NUM_REGS);

  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          busy;
  logic          wr_valid;
  logic [IW-1:0] wr_idx;
  logic [7:0]    wr_data;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_data;

  modport master (
    output scl_i, sda_i, rd_idx,
    input  sda_oe, busy, wr_valid, wr_idx, wr_data, rd_data
  );

  modport slave (
    input  scl_i, sda_i, rd_idx,
    output sda_oe, busy, wr_valid, wr_idx, wr_data, rd_data
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA and decodes edges plus START/STOP from a history flop.
// Define I2C_RTC_TARGET_GLITCH_FILT_EN to add a 3-sample agreement filter.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_level,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_lvl, sda_lvl;
  logic       scl_hist, sda_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_RTC_TARGET_GLITCH_FILT_EN
  // Level moves only once the current and two previous samples agree.
  logic [1:0] scl_smp, sda_smp;
  logic       scl_filt, sda_filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_smp  <= 2'b11;
      sda_smp  <= 2'b11;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      scl_smp  <= {scl_smp[0], scl_sync[1]};
      sda_smp  <= {sda_smp[0], sda_sync[1]};
      scl_filt <= scl_lvl;
      sda_filt <= sda_lvl;
    end
  end

  assign scl_lvl = (scl_sync[1] == scl_smp[0] && scl_smp[0] == scl_smp[1]) ? scl_sync[1] : scl_filt;
  assign sda_lvl = (sda_sync[1] == sda_smp[0] && sda_smp[0] == sda_smp[1]) ? sda_sync[1] : sda_filt;
`else
  assign scl_lvl = scl_sync[1];
  assign sda_lvl = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_hist <= scl_lvl;
      sda_hist <= sda_lvl;
    end
  end

  assign scl_rise  = scl_lvl & ~scl_hist;
  assign scl_fall  = ~scl_lvl & scl_hist;
  assign sda_level = sda_lvl;
  assign start_det = scl_lvl & scl_hist & sda_hist & ~sda_lvl;
  assign stop_det  = scl_lvl & scl_hist & ~sda_hist & sda_lvl;

endmodule

// File: rtl/i2c_rtc_target.sv
// I2C target holding the RTC register file: address match, pointer + burst
// writes, sequential reads. Glitch filter option: I2C_RTC_TARGET_GLITCH_FILT_EN.
module i2c_rtc_target
  import i2c_rtc_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int         NUM_REGS = 8
) (
  input  logic clk,
  input  logic reset,
  i2c_rtc_target_if.slave bus
);

  localparam int IW = $clog2(NUM_REGS);

  logic scl_rise, scl_fall, sda_lvl, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_level (sda_lvl),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d, rx_byte;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic          wr_en, wr_valid_q;
  logic [IW-1:0] wr_idx_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    regs [NUM_REGS];
  logic          addr_match;

  assign addr_match = (shift_q[7:1] == DEV_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= IW'(REG_SEC);
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_en;
      if (wr_en) begin
        regs[ptr_q] <= rx_byte;
        wr_idx_q    <= ptr_q;
        wr_data_q   <= rx_byte;
      end
    end
  end

  // Bus conditions win over any bit-level activity seen in the same cycle.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:       if (scl_fall && bit_cnt_q == 4'd8) state_d = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK:   if (scl_fall) state_d = shift_q[0] ? RDATA : PTR;
        PTR:        if (scl_fall && bit_cnt_q == 4'd8) state_d = PTR_ACK;
        PTR_ACK:    if (scl_fall) state_d = WDATA;
        WDATA:      if (scl_fall && bit_cnt_q == 4'd8) state_d = WDATA_ACK;
        WDATA_ACK:  if (scl_fall) state_d = WDATA;
        RDATA:      if (scl_fall && bit_cnt_q == 4'd8) state_d = RDATA_MACK;
        RDATA_MACK: begin
          if (scl_rise && sda_lvl == NACK_LVL) state_d = IGNORE;
          else if (scl_fall && bit_cnt_q != 4'd0) state_d = RDATA;
        end
        default: ;
      endcase
    end
  end

  // In RDATA_MACK a bit count of 1 records that the controller acknowledged.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en     = 1'b0;
    rx_byte   = {shift_q[6:0], sda_lvl};
    if (start_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == WDATA && bit_cnt_q == 4'd7) begin
              wr_en = 1'b1;
              ptr_d = ptr_q + IW'(1);
            end
          end
          if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q != ADDR || addr_match) sda_oe_d = (ACK_LVL == 1'b0);
            if (state_q == ADDR && addr_match) busy_d = 1'b1;
            if (state_q == PTR) ptr_d = shift_q[IW-1:0];
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            if (state_q == ADDR_ACK && shift_q[0]) begin
              shift_d  = regs[ptr_q];
              sda_oe_d = ~regs[ptr_q][7];
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RDATA_MACK: begin
          if (scl_rise && sda_lvl == ACK_LVL) begin
            ptr_d     = ptr_q + IW'(1);
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            bit_cnt_d = '0;
            shift_d   = regs[ptr_q];
            sda_oe_d  = ~regs[ptr_q][7];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_idx   = wr_idx_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_data  = regs[bus.rd_idx];

endmodule
